multi_channel_data_mux: RTL and testbench
=========================================

// Module: multi_channel_data_mux
// PURPOSE
//   Parametrised N-channel time-division data multiplexer with a registered output.
//   Selects one of NUM_CH input streams and dwells on it for a programmable number
//   of clocks. Four modes: idle, ascending rotation, descending rotation, fixed select.
//   Disabled channels are skipped. Sits between the source data registers and the
//   downstream serial/packing stage.
// PARAMETERS
//   NUM_CH  default 3  number of input channels (>=2)
//   DATA_W  default 8  width of each channel and of output_data
//   CNT_W   default 4  width of switch_clk_cycles and of the dwell counter
//   SEL_W   derived    $clog2(NUM_CH); width of channel index ports
// PORTS
//   clk                input   1               rising-edge clock
//   rst_n               input   1               synchronous reset, active low
//   ds_flat             input   NUM_CH*DATA_W   channel k = ds_flat[k*DATA_W +: DATA_W]
//   ch_en               input   NUM_CH          per-channel enable; 0 = skip channel
//   mode                input   2               00 IDLE, 01 ROT_UP, 10 ROT_DN, 11 FIXED
//   switch_clk_cycles   input   CNT_W           dwell length in clocks; 0 treated as 1
//   fixed_sel           input   SEL_W           channel index used in FIXED mode
//   output_data         output  DATA_W          registered selected data
//   out_valid           output  1               output_data belongs to an enabled channel
//   cur_ch              output  SEL_W           channel index currently driven
//   switch_pulse        output  1               1-cycle strobe on the cycle cur_ch changes
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): cur_ch=0, output_data=0, out_valid=0, switch_pulse=0,
//     dwell cnt=0. Reset overrides all other activity, including mid-dwell.
//   Dwell length D = (switch_clk_cycles==0) ? 1 : switch_clk_cycles.
//   Every edge: cur_ch <= next_ch; output_data <= ds[next_ch] sampled at that edge
//     (1-cycle latency from ds_flat to output_data); out_valid <= ch_en[next_ch] && mode!=00.
//   IDLE (00): next_ch=cur_ch; cnt<=0; output_data held (not re-sampled); out_valid<=0.
//   ROT_UP (01): cnt increments each clock; when cnt>=D-1: cnt<=0, next_ch = first
//     enabled channel after cur_ch in ascending order, wrapping NUM_CH-1 -> 0.
//   ROT_DN (10): as ROT_UP but descending order, wrapping 0 -> NUM_CH-1.
//   FIXED (11): next_ch=fixed_sel; cnt<=0; fixed_sel>=NUM_CH -> next_ch=cur_ch.
//   Skipping: search visits at most NUM_CH-1 other channels; if none enabled, cur_ch holds
//     (returns to itself only if enabled); out_valid follows ch_en[cur_ch].
//   All channels disabled: cur_ch holds, output_data holds, out_valid=0, cnt keeps wrapping.
//   switch_pulse <= (next_ch != cur_ch); cleared on all other cycles and in reset.
//   Mode change: cnt<=0 on the edge where mode differs from its previous-cycle value;
//     cur_ch is kept, and rotation resumes from it with a full D-cycle dwell.
//   switch_clk_cycles change mid-dwell: new D takes effect immediately; if cnt>=new D-1,
//     the switch happens on the next edge.
//   Enable dropped on the current channel mid-dwell: out_valid falls next edge;
//     cur_ch does not move until the dwell expires (or FIXED selects elsewhere).
//   No arithmetic overflow: cnt is CNT_W bits and never exceeds D-1.
// TESTING
//   NUM_CH=3, DS=AA/BB/CC, all en, mode=01, D=6, release reset -> output AA x6, BB x6,
//     CC x6, AA...; switch_pulse high once per 6 cycles; out_valid=1.
//   Same but mode=10, D=3 -> AA x3, CC x3, BB x3, AA...; wrap 0->2 checked.
//   mode=01, D=2, ch_en=3'b101 -> AA x2, CC x2, AA x2; BB never output.
//   ch_en=0 -> out_valid=0, output_data and cur_ch frozen, switch_pulse never fires.
//   mode=11, fixed_sel=1, change DS2 BB->EE mid-run -> output EE one cycle after change;
//     fixed_sel=3 -> cur_ch holds at 1.
//   D=0 and reset asserted mid-dwell -> D=0 switches every clock; reset gives cur_ch=0,
//     output_data=00, out_valid=0 on the next edge.

Source files
------------

// File: rtl/multi_channel_data_mux.sv
// Time-division multiplexer over NUM_CH input streams with programmable dwell,
// ascending/descending rotation that skips disabled channels, and a fixed-select mode.
module multi_channel_data_mux #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ds_flat,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [1:0]               mode,
  input  logic [CNT_W-1:0]         switch_clk_cycles,
  input  logic [SEL_W-1:0]         fixed_sel,
  output logic [DATA_W-1:0]        output_data,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     switch_pulse
);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DN    = 2'b10,
    MODE_FIXED = 2'b11
  } mode_e;

  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              pulse_q, pulse_d;

  logic [CNT_W-1:0]  dwell_last;
  logic              mode_chg;
  logic [SEL_W-1:0]  up_ch, dn_ch, cand_up, cand_dn;
  logic              up_found, dn_found;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    dwell_last = (switch_clk_cycles == '0) ? '0 : switch_clk_cycles - 1'b1;
    mode_chg   = (mode != mode_q);

    // Nearest enabled neighbour in each direction; falls back to the current channel.
    up_ch    = cur_ch_q;
    dn_ch    = cur_ch_q;
    up_found = 1'b0;
    dn_found = 1'b0;
    cand_up  = '0;
    cand_dn  = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      cand_up = SEL_W'((int'(cur_ch_q) + i) % NUM_CH);
      cand_dn = SEL_W'((int'(cur_ch_q) + NUM_CH - i) % NUM_CH);
      if (!up_found && ch_en[cand_up]) begin
        up_ch    = cand_up;
        up_found = 1'b1;
      end
      if (!dn_found && ch_en[cand_dn]) begin
        dn_ch    = cand_dn;
        dn_found = 1'b1;
      end
    end

    cur_ch_d = cur_ch_q;
    cnt_d    = '0;
    case (mode)
      MODE_UP, MODE_DN: begin
        // The first edge in a new mode only restarts the dwell.
        if (!mode_chg) begin
          if (cnt_q >= dwell_last) begin
            cur_ch_d = (mode == MODE_UP) ? up_ch : dn_ch;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MODE_FIXED: begin
        if (int'(fixed_sel) < NUM_CH) cur_ch_d = fixed_sel;
      end
      default: ;
    endcase

    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (SEL_W'(k) == cur_ch_d) sel_data = ds_flat[k*DATA_W +: DATA_W];
    end

    data_d  = ((mode == MODE_IDLE) || (ch_en == '0)) ? data_q : sel_data;
    valid_d = ch_en[cur_ch_d] && (mode != MODE_IDLE);
    pulse_d = (cur_ch_d != cur_ch_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_ch_q <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode;
      data_q   <= data_d;
      valid_q  <= valid_d;
      pulse_q  <= pulse_d;
    end
  end

  assign output_data  = data_q;
  assign out_valid    = valid_q;
  assign cur_ch       = cur_ch_q;
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_multi_channel_data_mux.sv
// Bench for multi_channel_data_mux: directed vector table, hand sequences for the
// long-dwell / fixed / reset corners, then random stimulus against a reference model.
module tb_multi_channel_data_mux;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int CW  = 4;
  localparam int SW  = 2;
  localparam int EW  = DW + SW + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*DW-1:0] ds_flat = {8'hCC, 8'hBB, 8'hAA};
  logic [NCH-1:0]    ch_en = '1;
  logic [1:0]        mode = 2'b00;
  logic [CW-1:0]     switch_clk_cycles = '0;
  logic [SW-1:0]     fixed_sel = '0;
  logic [DW-1:0]     output_data;
  logic              out_valid;
  logic [SW-1:0]     cur_ch;
  logic              switch_pulse;

  multi_channel_data_mux #(.NUM_CH(NCH), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ds_flat(ds_flat), .ch_en(ch_en), .mode(mode),
    .switch_clk_cycles(switch_clk_cycles), .fixed_sel(fixed_sel),
    .output_data(output_data), .out_valid(out_valid), .cur_ch(cur_ch),
    .switch_pulse(switch_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  int          m_cur = 0;
  int          m_cnt = 0;
  logic [1:0]  m_prev = 2'b00;
  logic [DW-1:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int next_enabled(input int cur, input int step);
    for (int k = 1; k < NCH; k++) begin
      int c;
      c = (((cur + step * k) % NCH) + NCH) % NCH;
      if (ch_en[c]) return c;
    end
    return cur;
  endfunction

  task automatic model_step();
    int d;
    int nxt;
    if (!rst_n) begin
      m_cur = 0; m_cnt = 0; m_prev = 2'b00;
      m_data = '0; m_valid = 1'b0; m_pulse = 1'b0;
    end else begin
      d   = (switch_clk_cycles == 0) ? 1 : int'(switch_clk_cycles);
      nxt = m_cur;
      if (mode == 2'b01 || mode == 2'b10) begin
        if (mode != m_prev) m_cnt = 0;
        else if (m_cnt + 1 >= d) begin
          m_cnt = 0;
          nxt = next_enabled(m_cur, (mode == 2'b01) ? 1 : -1);
        end else m_cnt++;
      end else begin
        m_cnt = 0;
        if (mode == 2'b11 && int'(fixed_sel) < NCH) nxt = int'(fixed_sel);
      end
      m_pulse = (nxt != m_cur);
      if (mode != 2'b00 && ch_en != '0) m_data = ds_flat[nxt*DW +: DW];
      m_valid = (mode != 2'b00) && ch_en[nxt];
      m_cur   = nxt;
      m_prev  = mode;
    end
    exp_q.push_back({m_valid, m_pulse, SW'(m_cur), m_data});
  endtask

  // driver: one clock with inputs already applied, then model comparison
  task automatic tick();
    logic [EW-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("m_valid", 32'(out_valid), 32'(e[EW-1]));
    check("m_pulse", 32'(switch_pulse), 32'(e[EW-2]));
    check("m_cur", 32'(cur_ch), 32'(e[DW +: SW]));
    check("m_data", 32'(output_data), 32'(e[DW-1:0]));
  endtask

  typedef struct {
    logic          rst_n;
    logic [1:0]    mode;
    logic [CW-1:0] d;
    logic [NCH-1:0] en;
    logic [SW-1:0] fsel;
    logic [DW-1:0] e_data;
    logic          e_valid;
    logic          e_pulse;
    logic [SW-1:0] e_cur;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic r, input logic [1:0] m, input int d, input logic [2:0] en,
                         input int fs, input logic [7:0] ed, input logic ev, input logic ep,
                         input int ec);
    vec_t v;
    v.rst_n = r; v.mode = m; v.d = CW'(d); v.en = en; v.fsel = SW'(fs);
    v.e_data = ed; v.e_valid = ev; v.e_pulse = ep; v.e_cur = SW'(ec);
    vq.push_back(v);
  endtask

  initial begin
    // rst mode D en fsel | data valid pulse cur
    add_vec(0, 2'b01, 2, 3'b111, 0, 8'h00, 0, 0, 0);
    add_vec(1, 2'b01, 2, 3'b111, 0, 8'hAA, 1, 0, 0);
    add_vec(1, 2'b01, 2, 3'b111, 0, 8'hAA, 1, 0, 0);
    add_vec(1, 2'b01, 2, 3'b111, 0, 8'hBB, 1, 1, 1);
    add_vec(1, 2'b01, 2, 3'b111, 0, 8'hBB, 1, 0, 1);
    add_vec(1, 2'b01, 2, 3'b111, 0, 8'hCC, 1, 1, 2);
    add_vec(1, 2'b01, 2, 3'b111, 0, 8'hCC, 1, 0, 2);
    add_vec(1, 2'b01, 2, 3'b111, 0, 8'hAA, 1, 1, 0);
    add_vec(1, 2'b01, 2, 3'b101, 0, 8'hAA, 1, 0, 0);
    add_vec(1, 2'b01, 2, 3'b101, 0, 8'hCC, 1, 1, 2);
    add_vec(1, 2'b01, 2, 3'b101, 0, 8'hCC, 1, 0, 2);
    add_vec(1, 2'b01, 2, 3'b101, 0, 8'hAA, 1, 1, 0);
    add_vec(1, 2'b01, 0, 3'b111, 0, 8'hBB, 1, 1, 1);
    add_vec(1, 2'b01, 0, 3'b111, 0, 8'hCC, 1, 1, 2);
    add_vec(1, 2'b10, 0, 3'b111, 0, 8'hCC, 1, 0, 2);
    add_vec(1, 2'b10, 0, 3'b111, 0, 8'hBB, 1, 1, 1);
    add_vec(1, 2'b10, 0, 3'b111, 0, 8'hAA, 1, 1, 0);
    add_vec(1, 2'b10, 0, 3'b111, 0, 8'hCC, 1, 1, 2);
    add_vec(1, 2'b11, 0, 3'b111, 1, 8'hBB, 1, 1, 1);
    add_vec(1, 2'b11, 0, 3'b111, 3, 8'hBB, 1, 0, 1);
    add_vec(1, 2'b00, 0, 3'b111, 3, 8'hBB, 0, 0, 1);
    add_vec(1, 2'b00, 0, 3'b111, 3, 8'hBB, 0, 0, 1);
    add_vec(1, 2'b01, 1, 3'b000, 0, 8'hBB, 0, 0, 1);
    add_vec(1, 2'b01, 1, 3'b000, 0, 8'hBB, 0, 0, 1);
    add_vec(0, 2'b01, 1, 3'b000, 0, 8'h00, 0, 0, 0);

    @(negedge clk);
    foreach (vq[i]) begin
      rst_n = vq[i].rst_n; mode = vq[i].mode; switch_clk_cycles = vq[i].d;
      ch_en = vq[i].en; fixed_sel = vq[i].fsel;
      tick();
      check($sformatf("v%0d_data", i), 32'(output_data), 32'(vq[i].e_data));
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vq[i].e_valid));
      check($sformatf("v%0d_pulse", i), 32'(switch_pulse), 32'(vq[i].e_pulse));
      check($sformatf("v%0d_cur", i), 32'(cur_ch), 32'(vq[i].e_cur));
    end

    // ascending rotation with a 6-cycle dwell
    rst_n = 0; ch_en = 3'b111; mode = 2'b01; switch_clk_cycles = 6; tick();
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      int ec;
      tick();
      ec = (i / 6) % 3;
      check("up6_cur", 32'(cur_ch), 32'(ec));
      check("up6_data", 32'(output_data), 32'(ds_flat[ec*DW +: DW]));
      check("up6_pulse", 32'(switch_pulse), 32'((i % 6 == 0) && (i > 0)));
    end

    // descending rotation with a 3-cycle dwell, wrapping 0 -> 2
    rst_n = 0; mode = 2'b10; switch_clk_cycles = 3; tick();
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      int seq[3];
      seq = '{0, 2, 1};
      tick();
      check("dn3_cur", 32'(cur_ch), 32'(seq[(i / 3) % 3]));
    end

    // fixed select follows live data; out-of-range select holds
    mode = 2'b11; fixed_sel = 1; tick();
    check("fix_cur", 32'(cur_ch), 32'd1);
    ds_flat[15:8] = 8'hEE; tick();
    check("fix_ee", 32'(output_data), 32'hEE);
    fixed_sel = 3; tick();
    check("fix_hold", 32'(cur_ch), 32'd1);
    ds_flat[15:8] = 8'hBB;

    // reset mid-dwell
    mode = 2'b01; switch_clk_cycles = 5; fixed_sel = 0;
    repeat (3) tick();
    rst_n = 0; tick();
    check("rst_data", 32'(output_data), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_cur", 32'(cur_ch), 32'h0);
    rst_n = 1;

    // random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      ds_flat = {8'($urandom), 8'($urandom), 8'($urandom)};
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) switch_clk_cycles = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0) ch_en = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) fixed_sel = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 40) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
